// File: rtl/pong_score_keeper.sv
// Score keeper for pong: edge-detects game flags, keeps BCD scores, runs the play/lockout/game-over
// FSM and scans a 4-digit seven-segment display. Optional rally counter: define SCORE_RALLY_EN.
module pong_score_keeper #(
    parameter int unsigned WIN_SCORE      = 11,
    parameter logic [23:0] LOCKOUT_CYCLES = 24'd1_600_000,
    parameter logic [16:0] REFRESH_DIV    = 17'd100_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       point_reset1,
    input  logic       point_reset2,
    input  logic       new_game,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic       game_over,
    output logic       winner,
`ifdef SCORE_RALLY_EN
    output logic [7:0] rally,
`endif
    output logic [3:0] anode,
    output logic [6:0] cathode
);

    localparam logic [6:0] WinBin = 7'(WIN_SCORE);

    typedef enum logic [1:0] {StPlay, StLockout, StGameOver} state_e;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    state_e      state;
    logic [23:0] lock_cnt;
    logic [3:0]  flags, flags_q, rise_q;
    logic        p1_point, p2_point;
    logic [7:0]  score1_inc, score2_inc;

    // Bit order: {hit2, hit1, point_reset2, point_reset1}
    assign flags      = {hit2, hit1, point_reset2, point_reset1};
    assign p1_point   = rise_q[1];
    assign p2_point   = rise_q[0];
    assign score1_inc = bcd_inc(score1);
    assign score2_inc = bcd_inc(score2);

    // Rises are registered so the FSM acts two cycles after a flag goes high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flags_q <= '0;
            rise_q  <= '0;
        end else begin
            flags_q <= flags;
            rise_q  <= flags & ~flags_q;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= StPlay;
            lock_cnt  <= '0;
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else if (new_game) begin
            state     <= StPlay;
            lock_cnt  <= '0;
            score1    <= '0;
            score2    <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            unique case (state)
                StPlay: begin
                    if (p1_point || p2_point) begin
                        lock_cnt <= LOCKOUT_CYCLES - 24'd1;
                        state    <= StLockout;
                        if (p1_point && !p2_point) begin
                            score1 <= score1_inc;
                            if (bcd_to_bin(score1_inc) == WinBin) begin
                                state     <= StGameOver;
                                game_over <= 1'b1;
                                winner    <= 1'b0;
                            end
                        end else if (p2_point && !p1_point) begin
                            score2 <= score2_inc;
                            if (bcd_to_bin(score2_inc) == WinBin) begin
                                state     <= StGameOver;
                                game_over <= 1'b1;
                                winner    <= 1'b1;
                            end
                        end
                    end
                end
                StLockout: begin
                    if (lock_cnt == 24'd0) state <= StPlay;
                    else lock_cnt <= lock_cnt - 24'd1;
                end
                StGameOver: begin
                end
                default: state <= StPlay;
            endcase
        end
    end

`ifdef SCORE_RALLY_EN
    logic [7:0] rally_q, rally_last_q;
    logic       point_evt;

    assign point_evt = (state == StPlay) && (p1_point || p2_point);
    assign rally     = rally_q;

    // The finished rally is kept aside so lockout can display it while a new one counts.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rally_q      <= '0;
            rally_last_q <= '0;
        end else if (new_game) begin
            rally_q      <= '0;
            rally_last_q <= '0;
        end else if (point_evt) begin
            rally_last_q <= rally_q;
            rally_q      <= '0;
        end else if (state != StGameOver) begin
            if (rise_q[2] && rise_q[3]) rally_q <= bcd_inc(bcd_inc(rally_q));
            else if (rise_q[2] || rise_q[3]) rally_q <= bcd_inc(rally_q);
        end
    end
`endif

    logic [16:0] refresh_cnt;
    logic [1:0]  digit_idx;
    logic [7:0]  left_pair, right_pair;
    logic        blank_left, blank_right;
    logic [6:0]  digit_seg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_DIV - 17'd1) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 17'd1;
        end
    end

    always_comb begin
        left_pair   = score1;
        right_pair  = score2;
        blank_left  = 1'b0;
        blank_right = 1'b0;
        digit_seg   = 7'h7F;
        if (state == StGameOver) begin
            blank_left  = winner;
            blank_right = ~winner;
        end
`ifdef SCORE_RALLY_EN
        if (state == StLockout) begin
            right_pair = rally_last_q;
            blank_left = 1'b1;
        end
`endif
        unique case (digit_idx)
            2'd0: digit_seg = blank_right ? 7'h7F : seg7(right_pair[3:0]);
            2'd1: digit_seg = (blank_right || right_pair[7:4] == 4'd0) ? 7'h7F
                                                                       : seg7(right_pair[7:4]);
            2'd2: digit_seg = blank_left ? 7'h7F : seg7(left_pair[3:0]);
            2'd3: digit_seg = (blank_left || left_pair[7:4] == 4'd0) ? 7'h7F
                                                                     : seg7(left_pair[7:4]);
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            anode   <= 4'b1110;
            cathode <= 7'h40;
        end else begin
            anode   <= ~(4'b0001 << digit_idx);
            cathode <= digit_seg;
        end
    end

endmodule

// File: tb/tb_pong_score_keeper.sv
// Randomized and directed bench for pong_score_keeper against a cycle-level behavioural model.
module tb_pong_score_keeper;

    localparam int unsigned WIN  = 11;
    localparam int          LOCK = 8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] flags;      // {hit2, hit1, point_reset2, point_reset1}
    logic       new_game;
    logic [7:0] score1, score2;
    logic       game_over, winner;
    logic [3:0] anode;
    logic [6:0] cathode;
`ifdef SCORE_RALLY_EN
    logic [7:0] rally;
`endif

    int n_vec = 0;
    int n_err = 0;

    int       m_s1, m_s2, m_lock, m_rally, m_rally_last;
    bit       m_over, m_winner;
    bit [3:0] m_prev, m_pend;

    logic [6:0] seg_tab [10];
    logic [6:0] seen_seg [4];
    bit         seen [4];

    pong_score_keeper #(
        .WIN_SCORE     (WIN),
        .LOCKOUT_CYCLES(24'd8),
        .REFRESH_DIV   (17'd2)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .hit1        (flags[2]),
        .hit2        (flags[3]),
        .point_reset1(flags[0]),
        .point_reset2(flags[1]),
        .new_game    (new_game),
        .score1      (score1),
        .score2      (score2),
        .game_over   (game_over),
        .winner      (winner),
`ifdef SCORE_RALLY_EN
        .rally       (rally),
`endif
        .anode       (anode),
        .cathode     (cathode)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int sat99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_lock = 0; m_rally = 0; m_rally_last = 0;
        m_over = 0; m_winner = 0; m_prev = '0; m_pend = '0;
    endfunction

    // One clock edge: act on rises seen at the previous edge, then detect new ones.
    function automatic void model_edge();
        int hits;
        hits = int'(m_pend[2]) + int'(m_pend[3]);
        if (new_game === 1'b1) begin
            m_s1 = 0; m_s2 = 0; m_lock = 0; m_over = 0; m_winner = 0;
            m_rally = 0; m_rally_last = 0;
        end else if (m_over) begin
        end else if (m_lock > 0) begin
            m_lock--;
            m_rally = sat99(m_rally + hits);
        end else if (m_pend[0] || m_pend[1]) begin
            m_rally_last = m_rally;
            m_rally = 0;
            if (m_pend[1] && !m_pend[0]) begin
                m_s1 = sat99(m_s1 + 1);
                if (m_s1 == int'(WIN)) begin m_over = 1; m_winner = 0; end
            end else if (m_pend[0] && !m_pend[1]) begin
                m_s2 = sat99(m_s2 + 1);
                if (m_s2 == int'(WIN)) begin m_over = 1; m_winner = 1; end
            end
            if (!m_over) m_lock = LOCK;
        end else begin
            m_rally = sat99(m_rally + hits);
        end
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = (flags[i] === 1'b1) && !m_prev[i];
            m_prev[i] = (flags[i] === 1'b1);
        end
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        int  l, r;
        bit  bl, br;
        l = m_s1; r = m_s2; bl = 0; br = 0;
        if (m_over) begin
            if (m_winner) bl = 1;
            else br = 1;
        end
`ifdef SCORE_RALLY_EN
        if (m_lock > 0) begin r = m_rally_last; bl = 1; end
`endif
        case (idx)
            0:       return br ? 7'h7F : seg_tab[r % 10];
            1:       return (br || r / 10 == 0) ? 7'h7F : seg_tab[r / 10];
            2:       return bl ? 7'h7F : seg_tab[l % 10];
            default: return (bl || l / 10 == 0) ? 7'h7F : seg_tab[l / 10];
        endcase
    endfunction

    function automatic int anode_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic cycle(input logic [3:0] f, input logic ng);
        flags = f;
        new_game = ng;
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] f);
        cycle(f, 1'b0);
        idle(19);
    endtask

    // Collect one cathode pattern per digit position over a bounded window.
    task automatic scan();
        int k;
        for (int i = 0; i < 4; i++) seen[i] = 0;
        for (int t = 0; t < 40; t++) begin
            k = anode_idx(anode);
            n_vec++;
            if (k < 0) begin
                n_err++;
                $display("FAIL anode_onehot: anode=%b, required exactly one low bit", anode);
            end else begin
                seen_seg[k] = cathode;
                seen[k] = 1;
            end
            cycle(4'b0000, 1'b0);
        end
        n_vec++;
        if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
            n_err++;
            $display("FAIL scan_complete: seen=%b%b%b%b, required all four digits",
                     seen[3], seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic check_display(input string name);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (seen_seg[k] !== exp_seg(k)) begin
                n_err++;
                $display("FAIL %s digit%0d: cathode=%h, required %h", name, k, seen_seg[k],
                         exp_seg(k));
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; flags = '0; new_game = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({score1, score2, game_over, winner} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_scores: got %h %h %b %b, required 00 00 0 0",
                     score1, score2, game_over, winner);
        end
        n_vec++;
        if (anode !== 4'b1110 || cathode !== 7'h40) begin
            n_err++;
            $display("FAIL reset_display: anode=%b cathode=%h, required 1110 40", anode, cathode);
        end
        @(negedge Clock); @(negedge Clock);
        Reset = 1'b0;
        idle(2);
    endtask

    task automatic test_hold_flag();
        cycle(4'b0010, 1'b0);
        n_vec++;
        if (score1 !== 8'h00) begin
            n_err++; $display("FAIL hold_latency1: score1=%h, required 00", score1);
        end
        cycle(4'b0010, 1'b0);
        n_vec++;
        if (score1 !== 8'h01) begin
            n_err++; $display("FAIL hold_latency2: score1=%h, required 01", score1);
        end
        for (int i = 0; i < 998; i++) cycle(4'b0010, 1'b0);
        n_vec++;
        if (score1 !== 8'h01 || score2 !== 8'h00 || score1 !== to_bcd(m_s1)) begin
            n_err++;
            $display("FAIL hold_once: score1=%h score2=%h, required 01 00", score1, score2);
        end
        idle(12);
    endtask

    task automatic test_both_same_cycle();
        logic [7:0] s1_before, s2_before;
        s1_before = score1; s2_before = score2;
        cycle(4'b0011, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b0);       // rise lands inside lockout
        idle(12);
        n_vec++;
        if (score1 !== s1_before || score2 !== s2_before) begin
            n_err++;
            $display("FAIL both_and_lockout: score1=%h score2=%h, required %h %h",
                     score1, score2, s1_before, s2_before);
        end
        pulse(4'b0010);
        n_vec++;
        if (score1 !== to_bcd(m_s1) || m_s1 != int'(s1_before) + 1) begin
            n_err++;
            $display("FAIL after_lockout: score1=%h, required %h", score1, to_bcd(m_s1));
        end
    endtask

    task automatic test_carry();
        cycle(4'b0000, 1'b1);
        idle(2);
        for (int i = 0; i < 10; i++) pulse(4'b0010);
        n_vec++;
        if (score1 !== 8'h10 || score2 !== 8'h00) begin
            n_err++;
            $display("FAIL bcd_carry: score1=%h score2=%h, required 10 00", score1, score2);
        end
        scan();
        check_display("carry_display");
        n_vec++;
        if (seen_seg[3] !== 7'h79) begin
            n_err++; $display("FAIL tens_one: cathode=%h, required 79", seen_seg[3]);
        end
    endtask

    task automatic test_game_over();
        cycle(4'b0000, 1'b1);
        idle(2);
        for (int i = 0; i < 11; i++) pulse(4'b0001);
        n_vec++;
        if (score2 !== 8'h11 || game_over !== 1'b1 || winner !== 1'b1) begin
            n_err++;
            $display("FAIL win_p2: score2=%h over=%b winner=%b, required 11 1 1",
                     score2, game_over, winner);
        end
        pulse(4'b0001);
        pulse(4'b0010);
        n_vec++;
        if (score2 !== 8'h11 || score1 !== 8'h00 || game_over !== 1'b1) begin
            n_err++;
            $display("FAIL frozen: score1=%h score2=%h over=%b, required 00 11 1",
                     score1, score2, game_over);
        end
        scan();
        check_display("gameover_display");
        cycle(4'b0000, 1'b1);
        n_vec++;
        if ({score1, score2, game_over, winner} !== 18'd0) begin
            n_err++;
            $display("FAIL new_game: got %h %h %b %b, required 00 00 0 0",
                     score1, score2, game_over, winner);
        end
    endtask

    task automatic test_async_reset();
        pulse(4'b0010);
        cycle(4'b0010, 1'b0);
        idle(1);
        for (int t = 0; t < 10 && anode == 4'b1110; t++) idle(1);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if ({score1, score2, game_over, winner} !== 18'd0 || anode !== 4'b1110
            || cathode !== 7'h40) begin
            n_err++;
            $display("FAIL async_reset: got %h %h %b %b %b %h, required 00 00 0 0 1110 40",
                     score1, score2, game_over, winner, anode, cathode);
        end
        @(negedge Clock);
        Reset = 1'b0;
        flags = '0;
        idle(2);
    endtask

    task automatic test_random();
        logic [3:0] f;
        f = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) f[i] = ~f[i];
            cycle(f, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            n_vec++;
            if ({score1, score2, game_over, winner} !==
                {to_bcd(m_s1), to_bcd(m_s2), m_over, m_winner}) begin
                n_err++;
                $display("FAIL random_state t=%0d: got %h %h %b %b, required %h %h %b %b", t,
                         score1, score2, game_over, winner, to_bcd(m_s1), to_bcd(m_s2),
                         m_over, m_winner);
            end
`ifdef SCORE_RALLY_EN
            n_vec++;
            if (rally !== to_bcd(m_rally)) begin
                n_err++;
                $display("FAIL random_rally t=%0d: rally=%h, required %h", t, rally,
                         to_bcd(m_rally));
            end
`endif
        end
        idle(12);
    endtask

`ifdef SCORE_RALLY_EN
    task automatic test_rally();
        int k;
        cycle(4'b0000, 1'b1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            cycle((i % 2 == 0) ? 4'b0100 : 4'b1000, 1'b0);
            idle(1);
        end
        idle(2);
        n_vec++;
        if (rally !== 8'h05) begin
            n_err++; $display("FAIL rally_count: rally=%h, required 05", rally);
        end
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        for (int t = 0; t < LOCK; t++) begin
            cycle(4'b0000, 1'b0);
            k = anode_idx(anode);
            if (m_lock >= 1 && m_lock <= LOCK - 1 && k >= 0) begin
                n_vec++;
                if (cathode !== exp_seg(k)) begin
                    n_err++;
                    $display("FAIL rally_display digit%0d: cathode=%h, required %h", k,
                             cathode, exp_seg(k));
                end
            end
        end
        idle(4);
        pulse(4'b0010);
        n_vec++;
        if (rally !== 8'h00 || m_rally_last != 0) begin
            n_err++; $display("FAIL rally_clear: rally=%h, required 00", rally);
        end
    endtask
`endif

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        test_reset();
        test_hold_flag();
        test_both_same_cycle();
        test_carry();
        test_game_over();
        test_async_reset();
        test_random();
`ifdef SCORE_RALLY_EN
        test_rally();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
